// File: rtl/psum_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_mem_ctrl
// Description : Partial-sum word array for the accelerator core. It has a
//               2-cycle write-first core read port, a lower-priority host
//               read port and a hardware zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    input  logic                  memctrl0_wren,
    input  logic [DATA_WIDTH-1:0] memctrl0_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl0_radd,
    input  logic                  memctrl0_rden,
    output logic [DATA_WIDTH-1:0] memctrl0_odat,
    output logic                  memctrl0_ovld,
    input  logic [ADDR_WIDTH-1:0] host_radd,
    input  logic                  host_rden,
    output logic                  host_rgnt,
    output logic [DATA_WIDTH-1:0] host_odat,
    output logic                  host_ovld,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  dbg_wr_cnt,
    output logic [REG_WIDTH-1:0]  dbg_rd_cnt
);

    localparam int                    c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [0:0]            c_IDLE       = 1'b0;
    localparam logic [0:0]            c_CLEAR      = 1'b1;
    localparam logic [DEPTH_LOG2-1:0] c_SWEEP_LAST = DEPTH_LOG2'(c_DEPTH - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic                  w_idle;
    logic                  w_busy;
    logic [DEPTH_LOG2-1:0] r_sweep;
    logic                  w_sweep_last;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0] w_wadd;
    logic [DEPTH_LOG2-1:0] w_radd;
    logic [DEPTH_LOG2-1:0] w_hadd;
    logic                  w_core_wr;
    logic                  w_core_rd;
    logic                  w_host_rd;
    logic                  w_drop;

    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_wa;
    logic [DATA_WIDTH-1:0] w_mem_wd;

    logic                  r_c_vld1;
    logic [DEPTH_LOG2-1:0] r_c_addr;
    logic                  r_c_byp;
    logic [DATA_WIDTH-1:0] r_c_bdat;
    logic                  r_c_vld2;
    logic [DATA_WIDTH-1:0] r_c_odat;

    logic                  r_h_vld1;
    logic [DEPTH_LOG2-1:0] r_h_addr;
    logic                  r_h_byp;
    logic [DATA_WIDTH-1:0] r_h_bdat;
    logic                  r_h_vld2;
    logic [DATA_WIDTH-1:0] r_h_odat;

    logic                  r_err;
    logic [REG_WIDTH-1:0]  r_wr_cnt;
    logic [REG_WIDTH-1:0]  r_rd_cnt;

    // Addresses wrap modulo the array depth; upper bits are deliberately ignored.
    assign w_wadd = memctrl0_wadd[DEPTH_LOG2-1:0];
    assign w_radd = memctrl0_radd[DEPTH_LOG2-1:0];
    assign w_hadd = host_radd[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_unused_addr
            logic w_unused;
            assign w_unused = ^{memctrl0_wadd[ADDR_WIDTH-1:DEPTH_LOG2],
                                memctrl0_radd[ADDR_WIDTH-1:DEPTH_LOG2],
                                host_radd[ADDR_WIDTH-1:DEPTH_LOG2]};
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (i_clear) w_next_state = c_CLEAR;
            c_CLEAR: if (w_sweep_last) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_idle = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_IDLE:  w_idle = 1'b1;
            c_CLEAR: w_busy = 1'b1;
            default: w_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep <= '0;
        end else if (w_busy) begin
            r_sweep <= r_sweep + DEPTH_LOG2'(1);
        end else begin
            r_sweep <= '0;
        end
    end

    assign w_sweep_last = w_busy && (r_sweep == c_SWEEP_LAST);

    // ------------------------------------------------------- access accept
    assign w_core_wr = w_idle & memctrl0_wren;
    assign w_core_rd = w_idle & memctrl0_rden;
    assign w_host_rd = w_idle & host_rden & ~memctrl0_rden;
    assign w_drop    = w_busy & (memctrl0_wren | memctrl0_rden);
    assign host_rgnt = w_host_rd;

    // Single write port shared by the core and the clear sweep; a held reset
    // blocks writes so a reset mid-sweep leaves the array exactly as it stands.
    assign w_mem_we = ~rst & (w_core_wr | w_busy);
    assign w_mem_wa = w_busy ? r_sweep : w_wadd;
    assign w_mem_wd = w_busy ? '0 : memctrl0_idat;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    // ------------------------------------------------------ core read pipe
    // The bypass data captured at acceptance keeps write-first behaviour
    // independent of when the array write lands relative to the array read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_vld1 <= 1'b0;
            r_c_addr <= '0;
            r_c_byp  <= 1'b0;
            r_c_bdat <= '0;
            r_c_vld2 <= 1'b0;
            r_c_odat <= '0;
        end else begin
            r_c_vld1 <= w_core_rd;
            if (w_core_rd) begin
                r_c_addr <= w_radd;
                r_c_byp  <= w_core_wr && (w_wadd == w_radd);
                r_c_bdat <= memctrl0_idat;
            end
            r_c_vld2 <= r_c_vld1;
            if (r_c_vld1) begin
                r_c_odat <= r_c_byp ? r_c_bdat : r_mem[r_c_addr];
            end
        end
    end

    // ------------------------------------------------------ host read pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_vld1 <= 1'b0;
            r_h_addr <= '0;
            r_h_byp  <= 1'b0;
            r_h_bdat <= '0;
            r_h_vld2 <= 1'b0;
            r_h_odat <= '0;
        end else begin
            r_h_vld1 <= w_host_rd;
            if (w_host_rd) begin
                r_h_addr <= w_hadd;
                r_h_byp  <= w_core_wr && (w_wadd == w_hadd);
                r_h_bdat <= memctrl0_idat;
            end
            r_h_vld2 <= r_h_vld1;
            if (r_h_vld1) begin
                r_h_odat <= r_h_byp ? r_h_bdat : r_mem[r_h_addr];
            end
        end
    end

    // ------------------------------------------------- status and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err    <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (w_core_wr) begin
                r_wr_cnt <= r_wr_cnt + REG_WIDTH'(1);
            end
            if (w_core_rd) begin
                r_rd_cnt <= r_rd_cnt + REG_WIDTH'(1);
            end
        end
    end

    assign memctrl0_odat = r_c_odat;
    assign memctrl0_ovld = r_c_vld2;
    assign host_odat     = r_h_odat;
    assign host_ovld     = r_h_vld2;
    assign o_busy        = w_busy;
    assign o_err         = r_err;
    assign dbg_wr_cnt    = r_wr_cnt;
    assign dbg_rd_cnt    = r_rd_cnt;

endmodule
`default_nettype wire
